// File: rtl/risc_me_pkg.sv
// ---------------------------------------------------------------------------
// risc_me_pkg
// Shared datapath definitions.
//   op_t           : write-port operation of the register bank
//                    (HOLD=00, LOAD=01, INC=10, DEC=11)
//   DATAPATH_WIDTH : default register width used across the datapath
//   op_writes()    : true when an op modifies its target register
// ---------------------------------------------------------------------------
package risc_me_pkg;

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_LOAD = 2'b01,
    OP_INC  = 2'b10,
    OP_DEC  = 2'b11
  } op_t;

  localparam int DATAPATH_WIDTH = 8;

  function automatic logic op_writes(input op_t op);
    return (op != OP_HOLD);
  endfunction

endpackage

// File: rtl/register_cell.sv
// ---------------------------------------------------------------------------
// register_cell
// One WIDTH-bit general-purpose register with load / increment / decrement.
// The next value and the wrap condition are computed from op alone so the
// bank can use them for read bypass and for its flags; the register only
// commits the next value when sel is high.
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-low reset (clears q)
//   sel      in   commit nxt at the next edge
//   op       in   operation (op_t)
//   data     in   WIDTH  load value
//   q        out  WIDTH  stored value
//   nxt      out  WIDTH  value that op would produce from q
//   wrap_hit out  1      op would wrap (INC from all-ones, DEC from zero)
// ---------------------------------------------------------------------------
module register_cell
  import risc_me_pkg::*;
#(
  parameter int WIDTH = DATAPATH_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sel,
  input  op_t              op,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] nxt,
  output logic             wrap_hit
);

  logic [WIDTH-1:0] r_q;

  always_comb begin
    nxt      = r_q;
    wrap_hit = 1'b0;
    case (op)
      OP_LOAD: nxt = data;
      OP_INC: begin
        nxt      = r_q + WIDTH'(1);
        wrap_hit = &r_q;
      end
      OP_DEC: begin
        nxt      = r_q - WIDTH'(1);
        wrap_hit = ~|r_q;
      end
      default: begin
        nxt      = r_q;
        wrap_hit = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q <= '0;
    end else if (sel) begin
      r_q <= nxt;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/register_bank.sv
// ---------------------------------------------------------------------------
// register_bank
// DEPTH general-purpose registers of WIDTH bits (WIDTH >= 2, DEPTH >= 2,
// DEPTH need not be a power of two) with one write/modify port and two
// gated read ports. Read ports drive zero when disabled so they can be
// OR-combined onto a shared bus.
// Parameters:
//   WIDTH  bits per register
//   DEPTH  number of registers
//   BYPASS 1: a read of the register being modified shows the new value
//   AW     address width, derived from DEPTH
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset (registers and flags)
//   data       in   WIDTH  load value
//   waddr      in   AW     target register of op (>= DEPTH: op ignored)
//   op         in   2      HOLD=00, LOAD=01, INC=10, DEC=11
//   raddr_a/b  in   AW     read addresses (>= DEPTH reads 0)
//   enable_a/b in   1      read output enables
//   reg_out_a/b out WIDTH  read data, zero when disabled
//   wrap       out  1      registered: last edge wrapped an INC/DEC
//   zero       out  1      registered: last modified register became zero
// ---------------------------------------------------------------------------
module register_bank
  import risc_me_pkg::*;
#(
  parameter  int WIDTH  = DATAPATH_WIDTH,
  parameter  int DEPTH  = 4,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data,
  input  logic [AW-1:0]    waddr,
  input  logic [1:0]       op,
  input  logic [AW-1:0]    raddr_a,
  input  logic             enable_a,
  output logic [WIDTH-1:0] reg_out_a,
  input  logic [AW-1:0]    raddr_b,
  input  logic             enable_b,
  output logic [WIDTH-1:0] reg_out_b,
  output logic             wrap,
  output logic             zero
);

  op_t              w_op;
  logic             w_in_range;
  logic             w_act;
  logic [DEPTH-1:0] w_sel;
  logic [DEPTH-1:0] w_wrap_hit;
  logic [WIDTH-1:0] w_q   [DEPTH];
  logic [WIDTH-1:0] w_nxt [DEPTH];
  logic [WIDTH-1:0] w_new_val;
  logic             w_wrap_set;
  logic [WIDTH-1:0] w_rd_a;
  logic [WIDTH-1:0] w_rd_b;
  logic             r_wrap;
  logic             r_zero;

  assign w_op = op_t'(op);

  // Addresses past the last register exist whenever DEPTH is not a power
  // of two; an op aimed there must behave exactly like HOLD.
  assign w_in_range = (int'(waddr) < DEPTH);
  assign w_act      = w_in_range && op_writes(w_op);

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cell
      assign w_sel[gi] = w_act && (waddr == AW'(gi));

      register_cell #(
        .WIDTH (WIDTH)
      ) u_cell (
        .clk      (clk),
        .reset    (reset),
        .sel      (w_sel[gi]),
        .op       (w_op),
        .data     (data),
        .q        (w_q[gi]),
        .nxt      (w_nxt[gi]),
        .wrap_hit (w_wrap_hit[gi])
      );
    end
  endgenerate

  // Value being committed this cycle; at most one select is ever high.
  always_comb begin
    w_new_val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_sel[i]) begin
        w_new_val = w_nxt[i];
      end
    end
  end

  assign w_wrap_set = |(w_sel & w_wrap_hit);

  // wrap is refreshed on every edge; zero only moves on an effective op.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wrap <= 1'b0;
      r_zero <= 1'b0;
    end else begin
      r_wrap <= w_wrap_set;
      if (w_act) begin
        r_zero <= (w_new_val == '0);
      end
    end
  end

  // Read muxes. An out-of-range address matches no cell and reads zero.
  // With bypass, the selected cell's pending value is forwarded.
  always_comb begin
    w_rd_a = '0;
    w_rd_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr_a == AW'(i)) begin
        w_rd_a = ((BYPASS != 0) && w_sel[i]) ? w_nxt[i] : w_q[i];
      end
      if (raddr_b == AW'(i)) begin
        w_rd_b = ((BYPASS != 0) && w_sel[i]) ? w_nxt[i] : w_q[i];
      end
    end
  end

  assign reg_out_a = enable_a ? w_rd_a : '0;
  assign reg_out_b = enable_b ? w_rd_b : '0;
  assign wrap      = r_wrap;
  assign zero      = r_zero;

endmodule

// File: doc/register_bank.md
# register_bank

Parametrised bank of DEPTH general-purpose registers, each WIDTH bits, replacing the single 8-bit latch/enable register in the datapath. It has one write/modify port and two gated read ports. The write port supports load, increment and decrement, so the same bank holds the accumulator, the B register and the PC/SP-style counters. Read ports drive zero when not enabled, so their outputs can be OR-combined onto the shared data bus.

## Interface

Parameters:
- WIDTH, 8: bits per register; must be at least 2.
- DEPTH, 4: number of registers; must be at least 2; need not be a power of two.
- BYPASS, 1: when 1, a read of the register being written this cycle returns the new value combinationally.
- AW, $clog2(DEPTH): address width (derived, not overridden).

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- data  in  WIDTH  load value for the write port.
- waddr  in  AW  target register of op.
- op  in  2  write-port operation: HOLD=00, LOAD=01, INC=10, DEC=11.
- raddr_a  in  AW  read port A address.
- enable_a  in  1  read port A output enable.
- reg_out_a  out  WIDTH  read port A data; zero when enable_a is low.
- raddr_b  in  AW  read port B address.
- enable_b  in  1  read port B output enable.
- reg_out_b  out  WIDTH  read port B data; zero when enable_b is low.
- wrap  out  1  registered; high for one cycle after an INC from all-ones or a DEC from zero.
- zero  out  1  registered; high when the register modified by the last non-HOLD op became zero.

## Operation

- reset low: all registers, wrap and zero clear to 0 immediately, independent of clk. All ops are ignored while reset is low.
- Reset release: the first rising edge with reset high may apply an op.
- LOAD: reg[waddr] <= data.
- INC: reg[waddr] <= reg[waddr] + 1, modulo 2^WIDTH.
- DEC: reg[waddr] <= reg[waddr] - 1, modulo 2^WIDTH.
- HOLD: no register changes.
- wrap:
  - Updated every edge.
  - Set to 1 when INC finds reg = all-ones, or DEC finds reg = 0.
  - Otherwise 0, including on HOLD and LOAD.
- zero:
  - Updated only on a non-HOLD op with an in-range waddr: set to (new value == 0).
  - On HOLD it keeps its value.
- waddr >= DEPTH: the op is ignored; wrap and zero behave as for HOLD.
- Reads:
  - reg_out_x = enable_x ? reg[raddr_x] : 0, purely combinational.
  - raddr_x >= DEPTH reads 0.
- Bypass:
  - With BYPASS=1, op != HOLD and raddr_x == waddr (in range), reg_out_x shows the value that will be written at the next edge.
  - With BYPASS=0, it shows the current stored value.
- Both read ports may address the same register, including the register being written.

## Timing

- Write latency: 1 cycle. A value applied before edge N is stored at edge N and visible on reads (BYPASS=0) immediately after edge N.
- Read latency: 0 cycles (combinational from stored state, enable and address).
- wrap and zero are valid after the same edge that commits the op.
- Back-to-back INC/DEC on one register every cycle is supported; each edge applies exactly one ±1.
- Reset asserted mid-sequence aborts it; the op pending at the next edge is lost.

## Structure

- Shared package risc_me_pkg holds:
  - the op_t enum (HOLD, LOAD, INC, DEC) with its 2-bit encoding;
  - the default WIDTH constant used by the datapath.
- Sub-module register_cell:
  - one WIDTH-bit register with async active-low reset;
  - inputs: sel, op, data;
  - outputs: q, next value, wrap_hit.
- register_bank instantiates DEPTH register_cells via generate. It adds address decode, the read muxes, bypass, output gating and the wrap/zero flags.

## Test plan

All scenarios use WIDTH=8, DEPTH=4, BYPASS=1 unless stated.

1. Reset: load 0xAA into r1, then pull reset low between edges -> reg_out_a (raddr_a=1, enable_a=1) reads 0x00 immediately; wrap=0, zero=0.
2. Load/gating: LOAD r2=0xAA, then r3=0x55 -> enable_a=1 with raddr_a=2 gives 0xAA; enable_b=1 with raddr_b=3 gives 0x55; deasserting either enable gives 0x00 on that port.
3. Counter wrap: LOAD r0=0xFE, then INC, INC -> r0 = 0xFF then 0x00; wrap=0 then 1; zero=0 then 1. A following HOLD gives wrap=0 and zero stays 1. DEC from 0x00 -> 0xFF with wrap=1.
4. Bypass: r1=0x10, op=INC on r1, raddr_a=1 in the same cycle -> reg_out_a=0x11 before the edge. Repeat with BYPASS=0 -> reg_out_a=0x10 before the edge and 0x11 after it.
5. Out of range (DEPTH=3): waddr=3 with LOAD 0x77 -> no register changes and flags behave as HOLD; raddr_a=3 reads 0x00.
6. Random: 2000 random ops, addresses and enables against a reference model -> all outputs match every cycle.
